keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. Divides the system clock into a scan tick, strobes one-hot rows, debounces column returns, and waits for key release. Each debounced press goes out as one key event on a valid/ready handshake. It sits between the keypad pins and the display/command logic.

## Interface
- `TICK_DIV`, default 50000: clk cycles per scan tick (>=2).
- `DEBOUNCE_TICKS`, default 4: consecutive matching samples needed to accept a press or a release (>=1).
- `REPEAT_TICKS`, default 64: auto-repeat period in ticks. Used only with `KEYPAD_REPEAT_EN`.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `col`  in  4: column returns, active-high, already synchronized upstream.
- `row`  out  4: one-hot row strobe.
- `key_valid`  out  1: key event available.
- `key_ready`  in  1: consumer accepts the event.
- `key_code`  out  4: key index, 4*r + c.
- `key_raw`  out  8: `{row, col}` as latched.
- `overrun`  out  1: sticky flag, an event was dropped.

## Operation
- Tick: a counter runs 0..TICK_DIV-1. `tick` is a one-clk internal pulse when the count equals TICK_DIV-1.
- All FSM decisions happen only on tick cycles. `col` is sampled on the tick, a full tick period after `row` changed.
- Index mapping:
  - r = 0,1,2,3 for row 1000, 0100, 0010, 0001.
  - c = 0,1,2,3 for col 1000, 0100, 0010, 0001.
- Row advance order: 1000 -> 0100 -> 0010 -> 0001 -> 1000. Any non-one-hot `row` goes to 1000.
- FSM states:
  - SCAN:
    - col==0, or more than one col bit set: advance row (multi-key is rejected).
    - Exactly one bit set: latch col, clear the debounce count to 1, go DEBOUNCE. Row is held.
  - DEBOUNCE:
    - col==latched col: increment the count. When the count reaches DEBOUNCE_TICKS, emit an event and go HELD.
    - Otherwise: go SCAN and advance row.
    - If DEBOUNCE_TICKS==1, the event is emitted on the detecting tick itself and the FSM goes straight to HELD.
  - HELD: row is held.
    - col==0: increment the release count. At DEBOUNCE_TICKS, go SCAN and advance row.
    - Any nonzero col: clear the release count.
- Emit rules:
  - An emit loads `key_code` and `key_raw`, and sets `key_valid`.
  - If `key_valid` is already 1 and not being accepted in that cycle, the new event is dropped and `overrun` is set. `overrun` clears only on reset.
- Handshake:
  - A transfer occurs on a clk edge with `key_valid && key_ready`. `key_valid` clears after the transfer.
  - `key_code` and `key_raw` stay stable while `key_valid` is 1.
  - Accept and emit in the same cycle: the new event loads and `key_valid` stays 1. No overrun.
- Reset mid-operation: any state returns to SCAN with the counters cleared, and a pending event is discarded.

## Timing
- Reset values: `row`=4'b1000, `key_valid`=0, `key_code`=0, `key_raw`=0, `overrun`=0, FSM=SCAN, all counters=0.
- First tick: the TICK_DIV-th clk edge after `reset` deasserts.
- `row` changes on the clk edge of a tick and is stable for TICK_DIV clks.
- Press latency: detected on tick T0 -> `key_valid`=1 on the edge of tick T0+DEBOUNCE_TICKS-1. It is visible the cycle after that tick.
- Release: scanning resumes on the DEBOUNCE_TICKS-th consecutive zero tick.
- Outputs are registered. There is no combinational path from `col` or `key_ready` to any output.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in HELD, a repeat counter counts ticks while col==latched col. At REPEAT_TICKS it emits the same code again and restarts. The counter clears on entry to HELD and whenever col differs from the latched col.
- Not defined: exactly one event per press. `REPEAT_TICKS` is ignored and no repeat logic is synthesized.

## Test plan
All scenarios use TICK_DIV=4 and DEBOUNCE_TICKS=3.
- Idle, col=0 for 20 ticks -> `row` cycles 1000, 0100, 0010, 0001, changing every 4 clk. `key_valid` stays 0 and `overrun` stays 0.
- Press row 0100 / col 0010, held for 10 ticks with `key_ready`=1 -> one event: `key_code`=6, `key_raw`=8'h42. Release -> `row` advances to 0010 on the 3rd zero tick.
- Bounce: col=0010 on 2 ticks, then 0 -> no event. FSM returns to SCAN and `row` advances.
- `key_ready`=0, two separate presses (code 0 then code 15) -> `key_valid`=1 with `key_code`=0 held, `overrun`=1, code 15 dropped. Raise `key_ready` -> one transfer, then `key_valid`=0.
- col=0011 on a row -> no event and scanning continues. With `KEYPAD_REPEAT_EN` and REPEAT_TICKS=5, holding key 5 for 20 ticks after accept -> 4 additional events with code 5.
- Assert `reset` during DEBOUNCE and during HELD with `key_valid`=1 -> next cycle `row`=1000, `key_valid`=0, `overrun`=0, and no event afterwards.

Source files
------------

// File: rtl/keypad_if.sv
// Key event channel between the keypad scanner (master) and its consumer (slave).
// The producer holds key_code/key_raw stable while key_valid is high; a transfer
// happens on any clk edge where key_valid && key_ready.
interface keypad_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic [7:0] key_raw;
  logic       overrun;

  modport master (
    output key_valid,
    output key_code,
    output key_raw,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_raw,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scan controller.
// Strobes one-hot rows at a divided tick rate, debounces a single-column return,
// waits for release, and publishes one key event per press on a valid/ready channel.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_TICKS   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  keypad_if.master   kbus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [3:0]     row_d;
  logic [3:0]     col_lat_q, col_lat_d;
  logic [DW-1:0]  db_cnt_q, db_cnt_d;
  logic [DW-1:0]  rel_cnt_q, rel_cnt_d;
  logic           emit_c;

  logic           key_valid_q, key_valid_d;
  logic [3:0]     key_code_q, key_code_d;
  logic [7:0]     key_raw_q, key_raw_d;
  logic           overrun_q, overrun_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
`else
  // Repeat period has no effect when auto-repeat is not built in.
  logic unused_repeat_ticks;
  assign unused_repeat_ticks = ^REPEAT_TICKS;
`endif

  // Row rotation 1000 -> 0100 -> 0010 -> 0001 -> 1000; anything else restarts at 1000.
  function automatic logic [3:0] next_row(input logic [3:0] r);
    logic [3:0] n;
    case (r)
      4'b1000: n = 4'b0100;
      4'b0100: n = 4'b0010;
      4'b0010: n = 4'b0001;
      default: n = 4'b1000;
    endcase
    return n;
  endfunction

  // Position of the set bit, MSB first (1000 -> 0).
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] i;
    case (v)
      4'b1000: i = 2'd0;
      4'b0100: i = 2'd1;
      4'b0010: i = 2'd2;
      4'b0001: i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Scan tick divider: free-running 0..TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row         <= 4'b1000;
      col_lat_q   <= 4'b0000;
      db_cnt_q    <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_raw_q   <= 8'h00;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row         <= row_d;
      col_lat_q   <= col_lat_d;
      db_cnt_q    <= db_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_raw_q   <= key_raw_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  // Scan/debounce/release decisions, taken only on tick cycles.
  always_comb begin
    state_d   = state_q;
    row_d     = row;
    col_lat_d = col_lat_q;
    db_cnt_d  = db_cnt_q;
    rel_cnt_d = rel_cnt_q;
    emit_c    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d = (state_q == HELD) ? rep_cnt_q : '0;
`endif

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (is_onehot(col)) begin
            col_lat_d = col;
            db_cnt_d  = DW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              emit_c    = 1'b1;
              state_d   = HELD;
              rel_cnt_d = '0;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = next_row(row);
          end
        end

        DEBOUNCE: begin
          if (col == col_lat_q) begin
            db_cnt_d = db_cnt_q + DW'(1);
            if ((db_cnt_q + DW'(1)) == DW'(DEBOUNCE_TICKS)) begin
              emit_c    = 1'b1;
              state_d   = HELD;
              rel_cnt_d = '0;
            end
          end else begin
            state_d  = SCAN;
            db_cnt_d = '0;
            row_d    = next_row(row);
          end
        end

        HELD: begin
          if (col == 4'b0000) begin
            if ((rel_cnt_q + DW'(1)) == DW'(DEBOUNCE_TICKS)) begin
              state_d   = SCAN;
              rel_cnt_d = '0;
              db_cnt_d  = '0;
              row_d     = next_row(row);
            end else begin
              rel_cnt_d = rel_cnt_q + DW'(1);
            end
          end else begin
            rel_cnt_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          // Auto-repeat while the same column stays asserted.
          if (col == col_lat_q) begin
            if ((rep_cnt_q + RW'(1)) == RW'(REPEAT_TICKS)) begin
              emit_c    = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + RW'(1);
            end
          end else begin
            rep_cnt_d = '0;
          end
`endif
        end

        default: begin
          state_d = SCAN;
          row_d   = 4'b1000;
        end
      endcase
    end
  end

  // Event register: emit loads unless an unaccepted event is still pending.
  // On every emit path col equals the latched column, so col supplies the index.
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_raw_d   = key_raw_q;
    overrun_d   = overrun_q;

    if (key_valid_q && kbus.key_ready) begin
      key_valid_d = 1'b0;
    end

    if (emit_c) begin
      if (key_valid_q && !kbus.key_ready) begin
        overrun_d = 1'b1;
      end else begin
        key_valid_d = 1'b1;
        key_code_d  = {onehot_idx(row), onehot_idx(col)};
        key_raw_d   = {row, col};
      end
    end
  end

  assign kbus.key_valid = key_valid_q;
  assign kbus.key_code  = key_code_q;
  assign kbus.key_raw   = key_raw_q;
  assign kbus.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5.
module tb_keypad_scan_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned RP = 5;
`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_EVENTS = 5;
`else
  localparam int HOLD_EVENTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;

  int         checks = 0;
  int         errors = 0;
  int         ev_cnt = 0;
  logic [3:0] last_code = 4'h0;

  keypad_if kb ();

  keypad_scan_ctrl #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DB),
    .REPEAT_TICKS  (RP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .col  (col),
    .row  (row),
    .kbus (kb.master)
  );

  always #5 clk = ~clk;

  // Count completed transfers as seen at the clock edge.
  always @(posedge clk) begin
    if (!reset && kb.key_valid && kb.key_ready) begin
      ev_cnt    <= ev_cnt + 1;
      last_code <= kb.key_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next tick edge.
  task automatic next_tick();
    repeat (TD) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) next_tick();
  endtask

  // Idle scan until the wanted row is strobed (bounded).
  task automatic goto_row(input logic [3:0] target);
    col = 4'b0000;
    for (int i = 0; i < 8 && row !== target; i++) next_tick();
    chk("goto_row", 32'(row), 32'(target));
  endtask

  function automatic logic [3:0] rot(input logic [3:0] r);
    return {r[0], r[3:1]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_row;

    reset = 1'b1;
    col = 4'b0000;
    kb.key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", 32'(row), 32'h8);
    chk("rst_valid", 32'(kb.key_valid), 32'h0);
    chk("rst_code", 32'(kb.key_code), 32'h0);
    chk("rst_raw", 32'(kb.key_raw), 32'h00);
    chk("rst_overrun", 32'(kb.overrun), 32'h0);
    reset = 1'b0;

    // Idle scanning for 20 ticks.
    exp_row = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      next_tick();
      exp_row = rot(exp_row);
      chk("idle_row", 32'(row), 32'(exp_row));
    end
    repeat (2) @(posedge clk);
    #1;
    chk("row_stable_mid_tick", 32'(row), 32'(exp_row));
    repeat (2) @(posedge clk);
    #1;
    chk("row_after_21", 32'(row), 32'h4);
    chk("idle_valid", 32'(kb.key_valid), 32'h0);
    chk("idle_overrun", 32'(kb.overrun), 32'h0);
    chk("idle_events", 32'(ev_cnt), 32'd0);

    // Press row 0100 / col 0010 -> code 6, raw 42.
    col = 4'b0010;
    kb.key_ready = 1'b1;
    next_tick();
    chk("press_row_held", 32'(row), 32'h4);
    next_tick();
    chk("press_not_yet", 32'(kb.key_valid), 32'h0);
    next_tick();
    chk("press_valid", 32'(kb.key_valid), 32'h1);
    chk("press_code", 32'(kb.key_code), 32'd6);
    chk("press_raw", 32'(kb.key_raw), 32'h42);
    ticks(7);
    chk("press_events", 32'(ev_cnt), 32'd1);
    chk("press_last_code", 32'(last_code), 32'd6);
    chk("press_valid_cleared", 32'(kb.key_valid), 32'h0);
    col = 4'b0000;
    ticks(2);
    chk("release_row_held", 32'(row), 32'h4);
    next_tick();
    chk("release_row_adv", 32'(row), 32'h2);

    // Bounce: two matching ticks then open.
    col = 4'b0010;
    next_tick();
    next_tick();
    chk("bounce_row_held", 32'(row), 32'h2);
    col = 4'b0000;
    next_tick();
    chk("bounce_row_adv", 32'(row), 32'h1);
    chk("bounce_events", 32'(ev_cnt), 32'd1);
    chk("bounce_valid", 32'(kb.key_valid), 32'h0);

    // Overrun: code 0 pending, code 15 dropped.
    kb.key_ready = 1'b0;
    goto_row(4'b1000);
    col = 4'b1000;
    ticks(3);
    chk("ovr_first_valid", 32'(kb.key_valid), 32'h1);
    chk("ovr_first_code", 32'(kb.key_code), 32'd0);
    chk("ovr_first_raw", 32'(kb.key_raw), 32'h88);
    chk("ovr_not_yet", 32'(kb.overrun), 32'h0);
    col = 4'b0000;
    ticks(3);
    chk("ovr_release_row", 32'(row), 32'h4);
    goto_row(4'b0001);
    col = 4'b0001;
    ticks(3);
    chk("ovr_flag", 32'(kb.overrun), 32'h1);
    chk("ovr_valid_held", 32'(kb.key_valid), 32'h1);
    chk("ovr_code_held", 32'(kb.key_code), 32'd0);
    chk("ovr_raw_held", 32'(kb.key_raw), 32'h88);
    col = 4'b0000;
    ticks(3);
    kb.key_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_xfer_valid", 32'(kb.key_valid), 32'h0);
    chk("ovr_xfer_events", 32'(ev_cnt), 32'd2);
    chk("ovr_xfer_code", 32'(last_code), 32'd0);
    repeat (TD - 1) @(posedge clk);
    #1;

    // Multi-key column pattern is rejected.
    goto_row(4'b0010);
    col = 4'b0011;
    next_tick();
    chk("multi_row1", 32'(row), 32'h1);
    next_tick();
    chk("multi_row2", 32'(row), 32'h8);
    chk("multi_valid", 32'(kb.key_valid), 32'h0);
    chk("multi_events", 32'(ev_cnt), 32'd2);

    // Hold key 5 for 20 ticks after the event.
    goto_row(4'b0100);
    col = 4'b0100;
    ticks(3);
    chk("hold_code", 32'(kb.key_code), 32'd5);
    ticks(20);
    col = 4'b0000;
    ticks(3);
    chk("hold_events", 32'(ev_cnt), 32'(2 + HOLD_EVENTS));
    chk("hold_last_code", 32'(last_code), 32'd5);
    chk("hold_release_row", 32'(row), 32'h2);

    // Reset during DEBOUNCE (overrun is still set from earlier).
    goto_row(4'b0100);
    col = 4'b0100;
    next_tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstdb_row", 32'(row), 32'h8);
    chk("rstdb_valid", 32'(kb.key_valid), 32'h0);
    chk("rstdb_overrun", 32'(kb.overrun), 32'h0);
    col = 4'b0000;
    reset = 1'b0;
    ticks(6);
    chk("rstdb_row_after", 32'(row), 32'h2);
    chk("rstdb_no_event", 32'(kb.key_valid), 32'h0);
    chk("rstdb_events", 32'(ev_cnt), 32'(2 + HOLD_EVENTS));

    // Reset during HELD with a pending event.
    kb.key_ready = 1'b0;
    goto_row(4'b0010);
    col = 4'b0010;
    ticks(3);
    chk("rsthd_valid", 32'(kb.key_valid), 32'h1);
    chk("rsthd_code", 32'(kb.key_code), 32'd10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rsthd_row", 32'(row), 32'h8);
    chk("rsthd_valid_clr", 32'(kb.key_valid), 32'h0);
    chk("rsthd_overrun", 32'(kb.overrun), 32'h0);
    chk("rsthd_code_clr", 32'(kb.key_code), 32'h0);
    col = 4'b0000;
    reset = 1'b0;
    ticks(4);
    chk("rsthd_no_event", 32'(kb.key_valid), 32'h0);
    chk("rsthd_events", 32'(ev_cnt), 32'(2 + HOLD_EVENTS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
